// File: rtl/vga_pkg.sv
// Shared VGA timing constants, FSM state encoding and counter helpers used by
// both the sync generator and the vga_rx timing receiver.
package vga_pkg;

  localparam int H_TPULSE = 192;
  localparam int H_TBP    = 32;
  localparam int H_TDISP  = 1280;
  localparam int H_TFP    = 97;
  localparam int H_TSYNC  = H_TPULSE + H_TBP + H_TDISP + H_TFP;

  localparam int V_TPULSE = 2;
  localparam int V_TBP    = 10;
  localparam int V_TDISP  = 480;
  localparam int V_TFP    = 30;
  localparam int V_TSYNC  = V_TPULSE + V_TBP + V_TDISP + V_TFP;

  localparam int H_W     = 11;
  localparam int V_W     = 10;
  localparam int RGB_W   = 3;
  localparam int MATCH_W = 3;

  localparam logic [H_W-1:0] H_MAX = 11'h7FF;
  localparam logic [V_W-1:0] V_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  function automatic logic [H_W-1:0] sat_inc_h(input logic [H_W-1:0] val);
    return (val == H_MAX) ? val : val + 11'd1;
  endfunction

  function automatic logic [V_W-1:0] sat_inc_v(input logic [V_W-1:0] val);
    return (val == V_MAX) ? val : val + 10'd1;
  endfunction

endpackage

// File: rtl/vga_rx_if.sv
// VGA pin bundle: active-low syncs plus one bit per colour channel.
interface vga_rx_if;
  logic hs;
  logic vs;
  logic r;
  logic g;
  logic b;

  modport master (output hs, output vs, output r, output g, output b);
  modport slave  (input hs, input vs, input r, input g, input b);
endinterface

// File: rtl/vga_edge_sync.sv
// Input register for a sync pin plus a delayed copy used for rise/fall detect.
module vga_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic cur_r;
  logic prev_r;

  // Syncs idle high, so reset to high to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r  <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      cur_r  <= din;
      prev_r <= cur_r;
    end
  end

  assign fall = prev_r & ~cur_r;
  assign rise = ~prev_r & cur_r;

endmodule

// File: rtl/vga_rx.sv
// VGA timing receiver: measures line/frame timing from HS/VS, locks after a
// run of identical frames and re-emits active pixel coordinates and colour.
module vga_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT_START = H_TPULSE + H_TBP,
  parameter int unsigned H_ACT_END   = H_TPULSE + H_TBP + H_TDISP,
  parameter int unsigned V_ACT_START = V_TPULSE + V_TBP,
  parameter int unsigned V_ACT_END   = V_TPULSE + V_TBP + V_TDISP,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_rx_if.slave          vga,
  output logic [H_W-1:0]   h_period,
  output logic [H_W-1:0]   h_pulse,
  output logic [V_W-1:0]   v_period,
  output logic [V_W-1:0]   v_pulse,
  output logic             locked,
  output logic             err,
  output logic             pix_valid,
  output logic [H_W-1:0]   pix_x,
  output logic [V_W-1:0]   pix_y,
  output logic [RGB_W-1:0] pix_rgb
);

  localparam logic [H_W-1:0]     H_A    = H_W'(H_ACT_START);
  localparam logic [H_W-1:0]     H_E    = H_W'(H_ACT_END);
  localparam logic [V_W-1:0]     V_A    = V_W'(V_ACT_START);
  localparam logic [V_W-1:0]     V_E    = V_W'(V_ACT_END);
  localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_FRAMES);

  logic hs_rise_s;
  logic hs_fall_s;
  logic vs_rise_s;
  logic vs_fall_s;

  logic [RGB_W-1:0] rgb_r;
  logic [RGB_W-1:0] rgb_d_r;

  logic [H_W-1:0] h_cnt_r;
  logic [V_W-1:0] v_cnt_r;
  logic [H_W-1:0] h_next_s;
  logic [V_W-1:0] v_meas_s;

  state_t             state_r;
  state_t             state_nx_s;
  logic [H_W-1:0]     ref_h_r;
  logic [H_W-1:0]     ref_h_nx_s;
  logic [V_W-1:0]     ref_v_r;
  logic [V_W-1:0]     ref_v_nx_s;
  logic [MATCH_W-1:0] match_r;
  logic [MATCH_W-1:0] match_nx_s;
  logic               fail_s;
  logic               h_bad_s;
  logic               v_bad_s;
  logic               sat_s;
  logic               lock_nx_s;
  logic               active_s;

  vga_edge_sync u_hs (
    .clk  (clk),
    .rst  (rst),
    .din  (vga.hs),
    .rise (hs_rise_s),
    .fall (hs_fall_s)
  );

  vga_edge_sync u_vs (
    .clk  (clk),
    .rst  (rst),
    .din  (vga.vs),
    .rise (vs_rise_s),
    .fall (vs_fall_s)
  );

  // Colour needs two stages so that rgb_d_r lines up with h_cnt_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r   <= 3'b000;
      rgb_d_r <= 3'b000;
    end else begin
      rgb_r   <= {vga.r, vga.g, vga.b};
      rgb_d_r <= rgb_r;
    end
  end

  assign h_next_s = sat_inc_h(h_cnt_r);
  assign v_meas_s = hs_fall_s ? sat_inc_v(v_cnt_r) : v_cnt_r;

  // Horizontal and vertical position counters; vs_fall takes priority for v.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_r <= 11'd0;
      v_cnt_r <= 10'd0;
    end else begin
      h_cnt_r <= hs_fall_s ? 11'd0 : h_next_s;
      if (vs_fall_s) begin
        v_cnt_r <= 10'd0;
      end else if (hs_fall_s) begin
        v_cnt_r <= sat_inc_v(v_cnt_r);
      end else begin
        v_cnt_r <= v_cnt_r;
      end
    end
  end

  // Period and pulse-width capture on the corresponding sync edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_period <= 11'd0;
      h_pulse  <= 11'd0;
      v_period <= 10'd0;
      v_pulse  <= 10'd0;
    end else begin
      if (hs_fall_s) h_period <= h_next_s;
      if (hs_rise_s) h_pulse  <= h_next_s;
      if (vs_fall_s) v_period <= v_meas_s;
      if (vs_rise_s) v_pulse  <= v_cnt_r;
    end
  end

  assign h_bad_s = hs_fall_s && (h_next_s != ref_h_r);
  assign v_bad_s = vs_fall_s && (v_meas_s != ref_v_r);
  assign sat_s   = (h_cnt_r == H_MAX) || (v_cnt_r == V_MAX);

  // Lock FSM next-state: measure one frame, then require LOCK_FRAMES matches.
  always_comb begin
    state_nx_s = state_r;
    ref_h_nx_s = ref_h_r;
    ref_v_nx_s = ref_v_r;
    match_nx_s = match_r;
    fail_s     = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        if (vs_fall_s) begin
          state_nx_s = ST_MEASURE;
        end else begin
          state_nx_s = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (hs_fall_s) begin
          ref_h_nx_s = h_next_s;
        end else begin
          ref_h_nx_s = ref_h_r;
        end
        if (vs_fall_s) begin
          ref_v_nx_s = v_meas_s;
          match_nx_s = 3'd0;
          state_nx_s = ST_CHECK;
        end else begin
          state_nx_s = ST_MEASURE;
        end
      end
      ST_CHECK: begin
        if (h_bad_s || v_bad_s) begin
          // Re-measure from this line; the new period becomes the reference.
          state_nx_s = ST_MEASURE;
          if (hs_fall_s) begin
            ref_h_nx_s = h_next_s;
          end else begin
            ref_h_nx_s = ref_h_r;
          end
        end else if (vs_fall_s) begin
          match_nx_s = match_r + 3'd1;
          if ((match_r + 3'd1) >= LOCK_M) begin
            state_nx_s = ST_LOCKED;
          end else begin
            state_nx_s = ST_CHECK;
          end
        end else begin
          state_nx_s = ST_CHECK;
        end
      end
      ST_LOCKED: begin
        if (h_bad_s || v_bad_s || sat_s) begin
          fail_s     = 1'b1;
          state_nx_s = ST_SEARCH;
        end else begin
          state_nx_s = ST_LOCKED;
        end
      end
      default: begin
        state_nx_s = ST_SEARCH;
      end
    endcase
  end

  assign lock_nx_s = (state_nx_s == ST_LOCKED);

  // Lock FSM state, references and the registered lock/error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SEARCH;
      ref_h_r <= 11'd0;
      ref_v_r <= 10'd0;
      match_r <= 3'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ref_h_r <= ref_h_nx_s;
      ref_v_r <= ref_v_nx_s;
      match_r <= match_nx_s;
      locked  <= lock_nx_s;
      err     <= fail_s;
    end
  end

  assign active_s = (h_cnt_r >= H_A) && (h_cnt_r < H_E) &&
                    (v_cnt_r >= V_A) && (v_cnt_r < V_E);

  // Pixel output; gated on the next lock state so it drops together with locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= 11'd0;
      pix_y     <= 10'd0;
      pix_rgb   <= 3'b000;
    end else begin
      pix_valid <= lock_nx_s && active_s;
      if (lock_nx_s && active_s) begin
        pix_x   <= h_cnt_r - H_A;
        pix_y   <= v_cnt_r - V_A;
        pix_rgb <= rgb_d_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// Self-checking bench for vga_rx using a reduced timing so several lock cycles fit.
module tb_vga_rx;
  import vga_pkg::*;

  localparam int TA  = 10;
  localparam int TE  = 34;
  localparam int TVA = 4;
  localparam int TVE = 16;
  localparam int PIX_PER_FRAME = (TE - TA) * (TVE - TVA);

  typedef struct {
    int line_len;
    int hs_low;
    int n_lines;
    int vs_low;
    int exp_h_period;
    int exp_h_pulse;
    int exp_v_period;
    int exp_v_pulse;
  } vec_t;

  typedef struct packed {
    logic [H_W-1:0]   x;
    logic [V_W-1:0]   y;
    logic [RGB_W-1:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  vga_rx_if vga ();

  logic [H_W-1:0]   h_period;
  logic [H_W-1:0]   h_pulse;
  logic [V_W-1:0]   v_period;
  logic [V_W-1:0]   v_pulse;
  logic             locked;
  logic             err;
  logic             pix_valid;
  logic [H_W-1:0]   pix_x;
  logic [V_W-1:0]   pix_y;
  logic [RGB_W-1:0] pix_rgb;

  vga_rx #(
    .H_ACT_START (TA),
    .H_ACT_END   (TE),
    .V_ACT_START (TVA),
    .V_ACT_END   (TVE),
    .LOCK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vga       (vga),
    .h_period  (h_period),
    .h_pulse   (h_pulse),
    .v_period  (v_period),
    .v_pulse   (v_pulse),
    .locked    (locked),
    .err       (err),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_rgb   (pix_rgb)
  );

  int   checks  = 0;
  int   errors  = 0;
  int   pix_cnt = 0;
  int   err_cnt = 0;
  pix_t sb_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int x, input int y);
    logic [31:0] xv;
    logic [31:0] yv;
    xv = x;
    yv = y;
    return {xv[2] ^ yv[1], xv[0], yv[0]};
  endfunction

  task automatic tick(input logic hs, input logic vs, input logic [2:0] rgb);
    @(posedge clk);
    #1;
    vga.hs = hs;
    vga.vs = vs;
    {vga.r, vga.g, vga.b} = rgb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 3'b000);
  endtask

  // One frame; VS falls with HS on line 0 and rises a little after HS on line vs_low.
  task automatic drive_frame(input int len, input int hsl, input int nl, input int vsl,
                             input bit expect_pix, input int short_line);
    int   ll;
    logic hs;
    logic vs;
    logic [2:0] rgb;
    pix_t e;
    for (int n = 0; n < nl; n++) begin
      ll = (n == short_line) ? len - 1 : len;
      for (int j = 0; j < ll; j++) begin
        hs = (j < hsl) ? 1'b0 : 1'b1;
        vs = ((n < vsl) || (n == vsl && j < hsl + 2)) ? 1'b0 : 1'b1;
        if (j >= TA && j < TE && n >= TVA && n < TVE) begin
          rgb = pat(j - TA, n - TVA);
          if (expect_pix) begin
            e.x   = 11'(j - TA);
            e.y   = 10'(n - TVA);
            e.rgb = rgb;
            sb_q.push_back(e);
          end
        end else begin
          rgb = 3'($urandom_range(0, 7));
        end
        tick(hs, vs, rgb);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_h_period"}, h_period, 0);
    check({tag, "_h_pulse"}, h_pulse, 0);
    check({tag, "_v_period"}, v_period, 0);
    check({tag, "_v_pulse"}, v_pulse, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_rgb"}, pix_rgb, 0);
  endtask

  // Output monitor: scoreboard pops on pix_valid, err pulse consistency.
  initial begin : monitor
    logic locked_q;
    pix_t e;
    locked_q = 1'b0;
    forever begin
      @(negedge clk);
      if (pix_valid === 1'b1) begin
        pix_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: got pixel x=%0d y=%0d, expected none", pix_x, pix_y);
        end else begin
          e = sb_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("pix_rgb", pix_rgb, e.rgb);
        end
      end
      if (err === 1'b1) begin
        err_cnt++;
        check("err_locked_low", locked, 0);
        check("err_was_locked", locked_q, 1);
        check("err_pix_valid_low", pix_valid, 0);
      end
      locked_q = locked;
    end
  end

  initial begin : watchdog
    #(20 * 80000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[3];
    int   p0;
    int   e0;

    vecs[0] = '{40, 6, 20, 2, 40, 6, 20, 2};
    vecs[1] = '{44, 4, 22, 3, 44, 4, 22, 3};
    vecs[2] = '{38, 8, 18, 1, 38, 8, 18, 1};

    vga.hs = 1'b1;
    vga.vs = 1'b1;
    vga.r  = 1'b0;
    vga.g  = 1'b0;
    vga.b  = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven timings: lock after 4 frames, then one more locked frame.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      p0 = pix_cnt;
      e0 = err_cnt;
      for (int f = 0; f < 5; f++) begin
        drive_frame(vecs[i].line_len, vecs[i].hs_low, vecs[i].n_lines, vecs[i].vs_low,
                    f >= 3, -1);
      end
      idle(4);
      @(negedge clk);
      check($sformatf("v%0d_h_period", i), h_period, vecs[i].exp_h_period);
      check($sformatf("v%0d_h_pulse", i), h_pulse, vecs[i].exp_h_pulse);
      check($sformatf("v%0d_v_period", i), v_period, vecs[i].exp_v_period);
      check($sformatf("v%0d_v_pulse", i), v_pulse, vecs[i].exp_v_pulse);
      check($sformatf("v%0d_locked", i), locked, 1);
      check($sformatf("v%0d_err_count", i), err_cnt - e0, 0);
      check($sformatf("v%0d_pix_count", i), pix_cnt - p0, 2 * PIX_PER_FRAME);
      check($sformatf("v%0d_sb_empty", i), sb_q.size(), 0);
    end

    // Short line in vertical blanking of a locked frame: err, then relock.
    do_reset();
    for (int f = 0; f < 4; f++) drive_frame(40, 6, 20, 2, f == 3, -1);
    e0 = err_cnt;
    p0 = pix_cnt;
    drive_frame(40, 6, 20, 2, 1'b1, 18);
    idle(4);
    @(negedge clk);
    check("short_err_count", err_cnt - e0, 1);
    check("short_locked", locked, 0);
    check("short_h_period", h_period, 39);
    for (int f = 0; f < 3; f++) drive_frame(40, 6, 20, 2, 1'b0, -1);
    @(negedge clk);
    check("short_not_yet_locked", locked, 0);
    drive_frame(40, 6, 20, 2, 1'b1, -1);
    idle(4);
    @(negedge clk);
    check("short_relocked", locked, 1);
    check("short_pix_count", pix_cnt - p0, 2 * PIX_PER_FRAME);
    check("short_err_total", err_cnt - e0, 1);

    // HS held high while locked: h_cnt saturates, err, no wrap.
    e0 = err_cnt;
    idle(2100);
    @(negedge clk);
    check("sat_err_count", err_cnt - e0, 1);
    check("sat_locked", locked, 0);
    for (int j = 0; j < 6; j++) tick(1'b0, 1'b1, 3'b000);
    @(negedge clk);
    check("sat_h_period", h_period, 2047);
    idle(20);
    p0 = pix_cnt;
    for (int f = 0; f < 4; f++) drive_frame(40, 6, 20, 2, f == 3, -1);
    idle(4);
    @(negedge clk);
    check("sat_relocked", locked, 1);
    check("sat_pix_count", pix_cnt - p0, PIX_PER_FRAME);
    check("sat_err_total", err_cnt - e0, 1);

    // One-cycle reset while locked clears everything; lock reacquired from scratch.
    e0 = err_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    p0 = pix_cnt;
    for (int f = 0; f < 3; f++) drive_frame(40, 6, 20, 2, 1'b0, -1);
    @(negedge clk);
    check("midrst_not_yet_locked", locked, 0);
    drive_frame(40, 6, 20, 2, 1'b1, -1);
    idle(4);
    @(negedge clk);
    check("midrst_relocked", locked, 1);
    check("midrst_pix_count", pix_cnt - p0, PIX_PER_FRAME);
    check("midrst_err_count", err_cnt - e0, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
# vga_rx

Timing receiver and pixel recoverer for the VGA stream: the consumer end of the VGA sync generator. Samples HS/VS/RGB on the 50 MHz system clock, measures line and frame timing, locks after consistent frames, and re-emits recovered pixel coordinates and colour. Sits on the VGA output pins as an in-system/bench monitor, so the generator can be checked without a scope.

## Interface
- H_ACT_START, 224: first active clock of a line, counted from the HS falling edge (h_cnt=0).
- H_ACT_END, 1504: first inactive clock after the active region (exclusive).
- V_ACT_START, 12: first active line, counted from the VS falling edge (v_cnt=0).
- V_ACT_END, 492: first inactive line (exclusive).
- LOCK_FRAMES, 2: consecutive matching frames required to assert locked (1..7).
- clk  in  1  50 MHz system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vga_HS, vga_VS  in  1 each  sync inputs, active-low pulses, same clock domain as clk.
- vga_R, vga_G, vga_B  in  1 each  colour inputs.
- h_period  out  11  clocks between successive HS falling edges (last complete line).
- h_pulse  out  11  HS low width in clocks (last line).
- v_period  out  10  lines (HS falls) between successive VS falling edges.
- v_pulse  out  10  VS low width in lines.
- locked  out  1  timing stable.
- err  out  1  one-cycle pulse on loss of lock.
- pix_valid  out  1  pix_* hold an active pixel.
- pix_x  out  11  h_cnt - H_ACT_START.
- pix_y  out  10  v_cnt - V_ACT_START.
- pix_rgb  out  3  {R,G,B} sampled.

## Operation
- Input stage: one register on HS, VS, R, G, B, plus a delayed copy of HS and VS for edge detect. hs_fall = prev & ~cur; hs_rise, vs_fall, vs_rise likewise.
- h_cnt (11b): 0 on hs_fall, else +1, saturating at 2047. hs_fall captures h_period = h_cnt+1; hs_rise captures h_pulse = h_cnt+1.
- v_cnt (10b): 0 on vs_fall, else +1 on hs_fall, saturating at 1023. vs_fall captures v_period = v_cnt + (hs_fall ? 1 : 0); vs_rise captures v_pulse = v_cnt. vs_fall wins over a simultaneous hs_fall for v_cnt.
- FSM states:
  - SEARCH: wait for vs_fall -> MEASURE.
  - MEASURE: latch ref_h at every hs_fall; at next vs_fall latch ref_v, clear match count -> CHECK.
  - CHECK: hs_fall with h_period != ref_h, or vs_fall with v_period != ref_v -> MEASURE (no err). Matching vs_fall increments match count; reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: any h_period/v_period mismatch, h_cnt reaching 2047 or v_cnt reaching 1023 -> err=1 for one cycle, locked=0, -> SEARCH.
- Active pixel: locked and H_ACT_START <= h_cnt < H_ACT_END and V_ACT_START <= v_cnt < V_ACT_END. pix_x/pix_y/pix_rgb registered with pix_valid; hold last value when pix_valid=0.
- Saturated counters do not wrap.

## Timing
- Reset: all outputs 0, h_cnt=v_cnt=0, FSM SEARCH, ref_h/ref_v/match count 0. Reset mid-lock takes effect on the next edge; lock is reacquired from scratch.
- Pin-to-edge latency 2 clocks (input reg + edge reg); measurement outputs update the cycle after the edge is detected.
- pix_* lag pins by 2 clocks; pix_x=0 corresponds to the pin sample H_ACT_START clocks after HS fell.
- locked rises the cycle after the LOCK_FRAMES-th matching vs_fall, i.e. SEARCH + 1 MEASURE frame + LOCK_FRAMES frames.
- err and locked deassertion occur on the same cycle; pix_valid is 0 from that cycle.

## Structure
- Package vga_pkg: VGA timing constants shared with the generator (TSYNC/TDISP/TPULSE/TFP, H and V), FSM state enum, counter widths.
- Sub-module vga_edge_sync: input register plus rise/fall detect, instantiated for HS and VS; RGB uses a plain register.

## Test plan
- Ideal stream: 1601-clock lines, HS low 192, 522 lines, VS low 2 lines -> locked after 4 frames; h_period=1601, h_pulse=192, v_period=522, v_pulse=2; err never set.
- Checkerboard RGB = x[5]^y[5] -> exactly 1280x480 = 614400 pix_valid cycles per locked frame; pix_x 0..1279, pix_y 0..479; rgb matches.
- After lock, one 1600-clock line -> err one cycle, locked=0 same cycle, relock after 4 further frames.
- HS held high after lock -> h_cnt saturates at 2047, err pulse, SEARCH; h_cnt stays 2047 until next hs_fall.
- hs_fall and vs_fall in the same cycle -> v_period counts that line, v_cnt=0, no false mismatch.
- rst asserted for 1 cycle while locked -> all outputs 0 next cycle; locked returns after 4 frames.
